// File: rtl/fill_engine.sv
// Pattern-fill source: pushes ceil(len/BPB) full-width beats of constant or
// incrementing bytes into the destination FIFO. FILL_INCR_EN enables incrementing mode.
module fill_engine #(
    parameter int DW = 64,
    parameter int LW = 24
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic [7:0]    pattern,
    input  logic          mode,
    input  logic          m_dst_full,
    input  logic          m_dst_almost_full,
    output logic          m_dst_putn,
    output logic [DW-1:0] m_dst,
    output logic          m_dst_last,
    output logic          m_endn,
    output logic          busy
);

    localparam int BPB = DW / 8;
    localparam int SH  = $clog2(BPB);
    localparam logic [LW-1:0] BPB_L = LW'(BPB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t        state_q;
    logic [LW-1:0] rem_q;
    logic [LW-1:0] rem_d;
    logic [7:0]    pat_q;
    logic          push;
    logic          last;

    assign push  = (state_q == S_RUN) && !m_dst_full;
    assign last  = (state_q == S_RUN) && (rem_q <= BPB_L);
    assign rem_d = (rem_q > BPB_L) ? (rem_q - BPB_L) : '0;

`ifdef FILL_INCR_EN
    logic          md_q;
    logic [LW-1:0] k_q;
    logic [7:0]    base;
    logic          unused_ok;

    assign unused_ok = m_dst_almost_full;
    // Beat k starts at pat + k*BPB; BPB is a power of two so the product is a shift.
    assign base = pat_q + 8'(k_q << SH);

    always_comb begin
        m_dst = '0;
        for (int i = 0; i < BPB; i++) begin
            m_dst[8*i +: 8] = md_q ? (base + 8'(i)) : pat_q;
        end
    end
`else
    logic unused_ok;

    assign unused_ok = ^{mode, m_dst_almost_full};
    assign m_dst     = {BPB{pat_q}};
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            pat_q   <= '0;
`ifdef FILL_INCR_EN
            md_q    <= 1'b0;
            k_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rem_q   <= len;
                        pat_q   <= pattern;
`ifdef FILL_INCR_EN
                        md_q    <= mode;
                        k_q     <= '0;
`endif
                        state_q <= (len != '0) ? S_RUN : S_END;
                    end
                end
                S_RUN: begin
                    if (push) begin
                        rem_q <= rem_d;
`ifdef FILL_INCR_EN
                        k_q   <= k_q + 1'b1;
`endif
                        if (last) state_q <= S_END;
                    end
                end
                S_END:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_dst_putn = !push;
    assign m_dst_last = last;
    assign m_endn     = (state_q != S_END);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fill_engine.sv
// Directed bench for fill_engine (DW=64): sequencing, back-pressure, reset abort
// and lane data in the build selected by FILL_INCR_EN.
module tb_fill_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] len = '0;
    logic [7:0]  pattern = '0;
    logic        mode = 1'b0;
    logic        full = 1'b0;
    logic        afull = 1'b0;
    logic        putn;
    logic [63:0] dst;
    logic        last;
    logic        endn;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    fill_engine #(.DW(64), .LW(24)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .len(len), .pattern(pattern),
        .mode(mode), .m_dst_full(full), .m_dst_almost_full(afull),
        .m_dst_putn(putn), .m_dst(dst), .m_dst_last(last), .m_endn(endn), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_beat(input logic [7:0] p, input logic incr, input int k);
        logic [63:0] r;
        logic [7:0]  b;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            b = incr ? 8'(int'(p) + k * 8 + i) : p;
            r[8*i +: 8] = b;
        end
        return r;
    endfunction

    // Starts an operation, then watches cycles 1..20 recording pushes, last, end and busy.
    task automatic run_op(input logic [23:0] l, input logic [7:0] p, input logic md,
                          input logic [31:0] full_mask, input int restart_cyc,
                          output logic [31:0] push_mask, output int last_cyc,
                          output int endn_cyc, output int busy_cnt,
                          output logic [63:0] first_beat);
        int   k;
        logic incr;
`ifdef FILL_INCR_EN
        incr = md;
`else
        incr = 1'b0;
`endif
        push_mask = '0; last_cyc = 0; endn_cyc = 0; busy_cnt = 0; first_beat = 'x; k = 0;
        @(negedge clk);
        start = 1'b1; len = l; pattern = p; mode = md;
        @(posedge clk); #1;
        start = 1'b0; len = 24'h000100; pattern = ~p; mode = ~md;
        for (int c = 1; c <= 20; c++) begin
            full  = full_mask[c];
            start = (c == restart_cyc);
            #1;
            if (!putn) begin
                push_mask[c] = 1'b1;
                if (k == 0) first_beat = dst;
                chk($sformatf("beat%0d_data", k), dst, model_beat(p, incr, k));
                if (last) last_cyc = c;
                k++;
            end
            if (!endn) endn_cyc = c;
            if (busy) busy_cnt++;
            @(posedge clk); #1;
        end
        full = 1'b0; start = 1'b0;
    endtask

    logic [31:0] pm;
    int          lc, ec, bc;
    logic [63:0] fb;

    initial begin
        #2;
        chk("rst_putn", 64'(putn), 64'd1);
        chk("rst_last", 64'(last), 64'd0);
        chk("rst_endn", 64'(endn), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dst",  dst, 64'd0);
        @(negedge clk); rst = 1'b0;

        // len 24 constant, stray start in cycle 2 must be ignored
        run_op(24'd24, 8'hA5, 1'b0, 32'h0, 2, pm, lc, ec, bc, fb);
        chk("l24_pushes", 64'(pm), 64'h0E);
        chk("l24_last",   64'(lc), 64'd3);
        chk("l24_endn",   64'(ec), 64'd4);
        chk("l24_busy",   64'(bc), 64'd4);
        chk("l24_beat0",  fb, 64'hA5A5A5A5A5A5A5A5);

        run_op(24'd20, 8'h5A, 1'b0, 32'h0, 0, pm, lc, ec, bc, fb);
        chk("l20_pushes", 64'(pm), 64'h0E);
        chk("l20_last",   64'(lc), 64'd3);
        chk("l20_endn",   64'(ec), 64'd4);

        run_op(24'd0, 8'h11, 1'b0, 32'h0, 0, pm, lc, ec, bc, fb);
        chk("l0_pushes", 64'(pm), 64'h0);
        chk("l0_endn",   64'(ec), 64'd1);
        chk("l0_busy",   64'(bc), 64'd1);

        run_op(24'd1, 8'h42, 1'b0, 32'h0, 0, pm, lc, ec, bc, fb);
        chk("l1_pushes", 64'(pm), 64'h02);
        chk("l1_last",   64'(lc), 64'd1);
        chk("l1_endn",   64'(ec), 64'd2);

        // full in cycles 2..4
        run_op(24'd32, 8'hC3, 1'b0, 32'h1C, 0, pm, lc, ec, bc, fb);
        chk("bp_pushes", 64'(pm), 64'hE2);
        chk("bp_last",   64'(lc), 64'd7);
        chk("bp_endn",   64'(ec), 64'd8);
        chk("bp_busy",   64'(bc), 64'd8);

`ifdef FILL_INCR_EN
        run_op(24'd16, 8'hFE, 1'b1, 32'h0, 0, pm, lc, ec, bc, fb);
        chk("inc_pushes", 64'(pm), 64'h06);
        chk("inc_beat0",  fb, 64'h050403020100FFFE);
`else
        run_op(24'd16, 8'h3C, 1'b1, 32'h0, 0, pm, lc, ec, bc, fb);
        chk("noinc_pushes", 64'(pm), 64'h06);
        chk("noinc_beat0",  fb, 64'h3C3C3C3C3C3C3C3C);
`endif

        // reset during beat 2 of 4
        @(negedge clk);
        start = 1'b1; len = 24'd32; pattern = 8'h77; mode = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        chk("ab_beat1_putn", 64'(putn), 64'd0);
        @(posedge clk); #1;
        chk("ab_beat2_putn", 64'(putn), 64'd0);
        #2; rst = 1'b1; #1;
        chk("ab_putn", 64'(putn), 64'd1);
        chk("ab_last", 64'(last), 64'd0);
        chk("ab_endn", 64'(endn), 64'd1);
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_dst",  dst, 64'd0);
        @(posedge clk); #1;
        chk("ab_endn_hold", 64'(endn), 64'd1);
        @(negedge clk); rst = 1'b0;

        run_op(24'd8, 8'h99, 1'b0, 32'h0, 0, pm, lc, ec, bc, fb);
        chk("post_pushes", 64'(pm), 64'h02);
        chk("post_last",   64'(lc), 64'd1);
        chk("post_endn",   64'(ec), 64'd2);
        chk("post_beat0",  fb, 64'h9999999999999999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
